// File: rtl/seg_scan_ctrl_pkg.sv
// Shared encodings and constants for the 7-segment scan controller.
package seg_scan_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  localparam int MAX_DIGITS = 8;
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;
  localparam logic SEG_BLANK = 1'b1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_refresh_timer.sv
// Digit-slot divider: counts 0..REFRESH_DIV-1 and flags the terminal count.
module seg_refresh_timer
  import seg_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int DIV_W       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam logic [DIV_W-1:0] TC = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with a tear-free pending/display buffer pair.
// Optional build macro LEADING_ZERO_BLANK_EN darkens leading zero digits above digit 0.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DIV_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [3:0]              dig_data,
  output logic                    dig_blank,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int VW    = 4 * NUM_DIGITS;
  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_e                  st_q, st_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    dead_q, dead_d;
  logic [VW-1:0]           disp_q, disp_d, pend_q, pend_d;
  logic                    pend_full_q, pend_full_d;
  logic                    ready_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [3:0]              data_q, data_d;
  logic                    blank_q, blank_d;
  logic                    ft_q, ft_d;

  logic                    scanning, clear, tick, frame_end, commit, accept, show;
  logic [NUM_DIGITS-1:0]   cur_sel, lz_dark;
  logic [3:0]              cur_nib;

  assign scanning  = (st_q == ST_SCAN) && enable;
  assign clear     = ~scanning;
  assign frame_end = scanning && tick && (idx_q == LAST_IDX);
  assign commit    = pend_full_q && (frame_end || (st_q == ST_IDLE));
  assign accept    = load_valid && ready_q;

  seg_refresh_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .DIV_W       (DIV_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .tick  (tick)
  );

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE: if (enable)  st_d = ST_SCAN;
      ST_SCAN: if (!enable) st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  // dead_q mirrors "divider at 0": the anti-ghost cycle at the start of every slot.
  always_comb begin
    idx_d  = idx_q;
    dead_d = 1'b0;
    if (clear) begin
      idx_d  = '0;
      dead_d = 1'b1;
    end else if (tick) begin
      idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      dead_d = 1'b1;
    end
  end

  always_comb begin
    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (commit) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end else if (accept) begin
      pend_d      = value_in;
      pend_full_d = 1'b1;
    end
  end

  always_comb begin
    cur_sel = '0;
    cur_nib = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_sel[k] = 1'b1;
        cur_nib    = disp_q[4*k +: 4];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_zero;
  always_comb begin
    lz_dark    = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (disp_q[4*k +: 4] == 4'h0);
      lz_dark[k] = (k > 0) && upper_zero;
    end
  end
`else
  assign lz_dark = '0;
`endif

  assign show = scanning && !dead_q && ((cur_sel & lz_dark) == '0);

  always_comb begin
    an_d    = ANODE_OFF[NUM_DIGITS-1:0];
    blank_d = SEG_BLANK;
    data_d  = '0;
    ft_d    = frame_end;
    if (show) begin
      an_d    = ~cur_sel;
      blank_d = 1'b0;
      data_d  = cur_nib;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= ST_IDLE;
      idx_q       <= '0;
      dead_q      <= 1'b1;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      ready_q     <= 1'b1;
      an_q        <= ANODE_OFF[NUM_DIGITS-1:0];
      data_q      <= '0;
      blank_q     <= SEG_BLANK;
      ft_q        <= 1'b0;
    end else begin
      st_q        <= st_d;
      idx_q       <= idx_d;
      dead_q      <= dead_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      ready_q     <= ~pend_full_d;
      an_q        <= an_d;
      data_q      <= data_d;
      blank_q     <= blank_d;
      ft_q        <= ft_d;
    end
  end

  assign load_ready = ready_q;
  assign dig_data   = data_q;
  assign dig_blank  = blank_q;
  assign an         = an_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (NUM_DIGITS=4, REFRESH_DIV=4).
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] value_in;
  logic        load_valid;
  logic        load_ready;
  logic [3:0]  dig_data;
  logic        dig_blank;
  logic [3:0]  an;
  logic        frame_tick;

  int n_checks = 0;
  int n_err    = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .DIV_W       (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .value_in   (value_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .dig_data   (dig_data),
    .dig_blank  (dig_blank),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ft(input string tag);
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (frame_tick === 1'b1) break;
    end
    chk(tag, 32'(frame_tick), 32'h1);
  endtask

  // Starts one cycle after a frame-end edge (dead cycle of digit 0), ends on the next frame-end edge.
  task automatic check_frame(input string tag, input logic [15:0] v);
    logic [3:0] one;
    logic [3:0] exp_an;
    logic       dark;
    one = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(1);
      chk({tag, "_dead_an"}, 32'(an), 32'hF);
      step(1);
      dark = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 0 && (v >> (4 * k)) == 16'h0) dark = 1'b1;
`endif
      exp_an = dark ? 4'hF : ~(one << k);
      chk({tag, "_an"}, 32'(an), 32'(exp_an));
      chk({tag, "_blank"}, 32'(dig_blank), 32'(dark));
      if (!dark) chk({tag, "_data"}, 32'(dig_data), 32'(v[4*k +: 4]));
      step(2);
    end
    chk({tag, "_ft"}, 32'(frame_tick), 32'h1);
  endtask

  initial begin
    int ft_cnt;
    rst        = 1'b1;
    enable     = 1'b0;
    value_in   = 16'h0;
    load_valid = 1'b0;
    step(2);
    chk("rst_an",    32'(an),         32'hF);
    chk("rst_data",  32'(dig_data),   32'h0);
    chk("rst_blank", 32'(dig_blank),  32'h1);
    chk("rst_ft",    32'(frame_tick), 32'h0);
    chk("rst_ready", 32'(load_ready), 32'h1);

    // 1: scan pattern from reset, disp=0
    rst    = 1'b0;
    enable = 1'b1;
    step(1); chk("p1_an", 32'(an), 32'hF); chk("p1_blank", 32'(dig_blank), 32'h1);
    step(1); chk("p2_an", 32'(an), 32'hF);
    step(1); chk("p3_an", 32'(an), 32'hE); chk("p3_blank", 32'(dig_blank), 32'h0);
             chk("p3_data", 32'(dig_data), 32'h0);
    step(1); chk("p4_an", 32'(an), 32'hE);
    step(1); chk("p5_an", 32'(an), 32'hE);
    step(1); chk("p6_an", 32'(an), 32'hF);
    step(1); chk("p7_an", 32'(an), 32'hD);
    step(9); chk("p16_ft", 32'(frame_tick), 32'h0);
    step(1); chk("p17_ft", 32'(frame_tick), 32'h1);
    ft_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step(1);
      if (frame_tick === 1'b1) ft_cnt++;
    end
    chk("ft_per_32", 32'(ft_cnt), 32'h2);
    chk("ft_at_49", 32'(frame_tick), 32'h1);

    // 2: mid-frame load of 1A3F
    step(5);
    chk("ld_ready_pre", 32'(load_ready), 32'h1);
    value_in   = 16'h1A3F;
    load_valid = 1'b1;
    step(1);
    load_valid = 1'b0;
    chk("ld_ready_fall", 32'(load_ready), 32'h0);
    chk("ld_old_an", 32'(an), 32'hD);
    chk("ld_old_data", 32'(dig_data), 32'h0);
    step(4);
    chk("ld_old_d2", 32'(dig_data), 32'h0);
    step(6);
    chk("ld_commit_ft", 32'(frame_tick), 32'h1);
    chk("ld_ready_back", 32'(load_ready), 32'h1);
    step(1);
    check_frame("f1A3F", 16'h1A3F);

    // 3: held valid while pending full
    step(3);
    value_in   = 16'h2B4C;
    load_valid = 1'b1;
    step(1);
    chk("h_ready0", 32'(load_ready), 32'h0);
    value_in = 16'h0007;
    step(11);
    chk("h_ready_still0", 32'(load_ready), 32'h0);
    step(1);
    chk("h_commit_ft", 32'(frame_tick), 32'h1);
    chk("h_commit_ready", 32'(load_ready), 32'h1);
    step(1);
    chk("h_taken", 32'(load_ready), 32'h0);
    load_valid = 1'b0;
    check_frame("f2B4C", 16'h2B4C);
    step(1);
    check_frame("f0007", 16'h0007);

    // 4: drop enable mid-slot of digit 2
    step(10);
    chk("en_d2_an", 32'(an), 32'hB);
    enable = 1'b0;
    step(1);
    chk("en_off_an", 32'(an), 32'hF);
    chk("en_off_blank", 32'(dig_blank), 32'h1);
    step(3);
    chk("en_idle_an", 32'(an), 32'hF);
    enable = 1'b1;
    step(1); chk("re_e1_an", 32'(an), 32'hF);
    step(1); chk("re_e2_an", 32'(an), 32'hF);
    step(1); chk("re_e3_an", 32'(an), 32'hE); chk("re_e3_data", 32'(dig_data), 32'h7);
    step(13); chk("re_e16_ft", 32'(frame_tick), 32'h0);
    step(1);  chk("re_e17_ft", 32'(frame_tick), 32'h1);

    // 5: reset during digit 3 with pending full
    value_in   = 16'h9999;
    load_valid = 1'b1;
    step(1);
    load_valid = 1'b0;
    chk("r_pend_full", 32'(load_ready), 32'h0);
    step(13);
    chk("r_d3_an", 32'(an), 32'h7);
    rst = 1'b1;
    #1;
    chk("r_an",    32'(an),         32'hF);
    chk("r_data",  32'(dig_data),   32'h0);
    chk("r_blank", 32'(dig_blank),  32'h1);
    chk("r_ft",    32'(frame_tick), 32'h0);
    chk("r_ready", 32'(load_ready), 32'h1);
    step(2);
    rst = 1'b0;
    step(3);
    chk("r_p3_an", 32'(an), 32'hE);
    chk("r_p3_data", 32'(dig_data), 32'h0);
    chk("r_p3_ready", 32'(load_ready), 32'h1);
    step(4);
    chk("r_p7_an", 32'(an), 32'hD);
    chk("r_p7_data", 32'(dig_data), 32'h0);

    // 6: leading-zero value 0050
    value_in   = 16'h0050;
    load_valid = 1'b1;
    step(1);
    load_valid = 1'b0;
    wait_ft("lz_wait_ft");
    step(1);
    check_frame("f0050", 16'h0050);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
